status_flag_unit: RTL
=====================

// Module: status_flag_unit
// PURPOSE
//  Producer side of the NZCV status bus read by the condition checker. Generates N/Z/C/V from EXE-stage ALU
//  results, holds them in the CPSR flag register, saves/restores them through a one-deep SPSR on exception
//  entry/return, and drives the registered and forwarded 4-bit status {N,Z,C,V} to the ID-stage condition
//  check. Sits between the EXE stage and the ID-stage condition logic.
// PARAMETERS
//  DATA_W     32  ALU result width used for N/Z generation
//  FWD_EN     1   1: status_fwd bypasses the pending EXE write; 0: status_fwd == status, hazard flagged
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  freeze       in   1       pipeline stall; holds all state
//  flush        in   1       kills the EXE-stage instruction this cycle (no flag write)
//  exe_valid    in   1       EXE stage holds a real instruction
//  exe_s        in   1       instruction's S bit (update flags)
//  alu_res      in   DATA_W  ALU result
//  alu_c        in   1       carry out from ALU/shifter
//  alu_v        in   1       overflow from ALU
//  alu_arith    in   1       1: arithmetic op (C,V updated); 0: logical op (C updated, V kept)
//  msr_we       in   1       direct flag write (MSR-style), EXE stage
//  msr_flags    in   4       {N,Z,C,V} value for msr_we
//  exc_enter    in   1       exception entry pulse
//  exc_return   in   1       exception return pulse
//  id_cond      in   4       condition field of ID-stage instruction
//  status       out  4       registered CPSR flags {N,Z,C,V}
//  status_fwd   out  4       flags the ID-stage condition check uses this cycle
//  cond_hazard  out  1       ID needs flags being produced in EXE and FWD_EN==0
//  in_exc       out  1       FSM is in EXC state
//  exc_err      out  1       one-cycle pulse: exc_enter in EXC or exc_return in USER
// BEHAVIOUR
//  - Reset: status=4'b0000, spsr=4'b0000, FSM=USER, in_exc=0, exc_err=0; reset mid-exception discards SPSR.
//  - Generation: N=alu_res[DATA_W-1]; Z=(alu_res==0); C=alu_c; V=alu_arith?alu_v:status[0].
//  - exe_wr = exe_valid & exe_s & ~flush. New flags visible on status one cycle after the write edge.
//  - Per-edge priority: rst > freeze (hold everything, exc_err=0) > exc_enter/exc_return > msr_we > exe_wr.
//  - msr_we & exe_wr same cycle: msr_flags win (illegal stream; bench asserts it never occurs).
//  - FSM USER: exc_enter -> EXC, spsr<=status (pre-update value; a concurrent exe_wr/msr_we is dropped).
//  - FSM EXC: exc_return -> USER, status<=spsr (concurrent exe_wr/msr_we dropped); flag writes allowed in EXC.
//  - exc_enter & exc_return same cycle: both ignored, exc_err=1. Illegal pulse in wrong state: ignored, exc_err=1.
//  - status_fwd (combinational): FWD_EN=1 and (msr_we|exe_wr) and not freeze/exc event -> next flag value;
//    otherwise status. FWD_EN=0 -> always status.
//  - cond_hazard = ~FWD_EN & (msr_we|exe_wr) & (id_cond!=4'd14); ID stage stalls one cycle on it.
//  - flush suppresses exe_wr only; msr_we and exc pulses are already qualified upstream.
// STRUCTURE
//  - Shared package (arm_pkg): NZCV bit indices (N=3,Z=2,C=1,V=0), condition code constants EQ..AL (AL=4'd14),
//    FSM state encoding USER/EXC.
//  - Sub-module nzcv_gen: combinational N/Z/C/V generator from alu_res/alu_c/alu_v/alu_arith/old V.
//  - Top: CPSR flag reg, SPSR reg, 2-state FSM, forward mux, hazard logic.
// TESTING
//  - Reset then exe_wr with alu_res=0, C=1, arith -> status=4'b0110 next cycle; status_fwd=0110 same cycle.
//  - Logical op alu_res=32'h8000_0000, C=0 after status V=1 -> status=4'b1001 (V kept).
//  - exe_wr with flush=1 or freeze=1 -> status unchanged; freeze released -> write then applied.
//  - status=1010, exc_enter; in EXC write 0100; exc_return -> status=1010, in_exc=0.
//  - exc_return in USER -> exc_err=1 one cycle, status unchanged; rst in EXC -> USER, status=0000.
//  - FWD_EN=0, exe_wr with id_cond=EQ -> cond_hazard=1; id_cond=AL -> cond_hazard=0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared NZCV definitions for the status flag unit.
// Bit indices, condition codes and the exception FSM states.
package arm_pkg;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;

  typedef enum logic {
    ST_USER = 1'b0,
    ST_EXC  = 1'b1
  } exc_state_e;

endpackage

// File: rtl/status_flag_unit_if.sv
// EXE-side flag sources and the NZCV status bus to ID.
// master drives the EXE inputs, slave is the flag unit.
interface status_flag_unit_if #(
  parameter int DATA_W = 32
);
  logic              exe_valid;
  logic              exe_s;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic              alu_arith;
  logic              msr_we;
  logic [3:0]        msr_flags;
  logic [3:0]        id_cond;
  logic [3:0]        status;
  logic [3:0]        status_fwd;
  logic              cond_hazard;

  modport master (
    output exe_valid, exe_s, alu_res,
    output alu_c, alu_v, alu_arith,
    output msr_we, msr_flags, id_cond,
    input  status, status_fwd, cond_hazard
  );

  modport slave (
    input  exe_valid, exe_s, alu_res,
    input  alu_c, alu_v, alu_arith,
    input  msr_we, msr_flags, id_cond,
    output status, status_fwd, cond_hazard
  );
endinterface

// File: rtl/nzcv_gen.sv
// Combinational NZCV generator for EXE-stage ALU results.
// Logical ops keep the old V; arithmetic ops take ALU V.
module nzcv_gen
  import arm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_res,
  input  logic              i_c,
  input  logic              i_v,
  input  logic              i_arith,
  input  logic              i_old_v,
  output logic [3:0]        o_flags
);

  // Build {N,Z,C,V} from the result and carry/overflow
  always_comb begin
    o_flags        = 4'b0000;
    o_flags[N_IDX] = i_res[DATA_W-1];
    o_flags[Z_IDX] = (i_res == '0);
    o_flags[C_IDX] = i_c;
    o_flags[V_IDX] = i_arith ? i_v : i_old_v;
  end

endmodule

// File: rtl/status_flag_unit.sv
// CPSR flag register, one-deep SPSR and exception FSM.
// Drives registered and forwarded NZCV to ID-stage cond check.
module status_flag_unit
  import arm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FWD_EN = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_freeze,
  input  logic                i_flush,
  input  logic                i_exc_enter,
  input  logic                i_exc_return,
  status_flag_unit_if.slave   bus,
  output logic                o_in_exc,
  output logic                o_exc_err
);

  localparam logic P_FWD = (FWD_EN != 0);

  logic [3:0] r_status;
  logic [3:0] r_spsr;
  exc_state_e r_state;
  logic       r_in_exc;
  logic       r_exc_err;

  logic [3:0] w_gen;
  logic [3:0] w_next;
  logic       w_exe_wr;
  logic       w_wr;
  logic       w_both;
  logic       w_enter;
  logic       w_return;
  logic       w_exc_evt;
  logic       w_exc_err;
  logic       w_take;

  nzcv_gen #(
    .DATA_W (DATA_W)
  ) u_gen (
    .i_res   (bus.alu_res),
    .i_c     (bus.alu_c),
    .i_v     (bus.alu_v),
    .i_arith (bus.alu_arith),
    .i_old_v (r_status[V_IDX]),
    .o_flags (w_gen)
  );

  assign w_exe_wr = bus.exe_valid & bus.exe_s & ~i_flush;
  assign w_wr     = bus.msr_we | w_exe_wr;
  assign w_next   = bus.msr_we ? bus.msr_flags : w_gen;

  assign w_both   = i_exc_enter & i_exc_return;
  assign w_enter  = i_exc_enter & ~w_both
                  & (r_state == ST_USER);
  assign w_return = i_exc_return & ~w_both
                  & (r_state == ST_EXC);
  assign w_exc_evt = w_enter | w_return;

  assign w_exc_err = w_both
    | (i_exc_enter & (r_state == ST_EXC))
    | (i_exc_return & (r_state == ST_USER));

  assign w_take = w_wr & ~i_freeze & ~w_exc_evt;

  // FSM, CPSR and SPSR update; exception moves beat flag writes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_status  <= 4'b0000;
      r_spsr    <= 4'b0000;
      r_state   <= ST_USER;
      r_in_exc  <= 1'b0;
      r_exc_err <= 1'b0;
    end else if (i_freeze) begin
      r_exc_err <= 1'b0;
    end else begin
      r_exc_err <= w_exc_err;
      if (w_enter) begin
        r_spsr   <= r_status;
        r_state  <= ST_EXC;
        r_in_exc <= 1'b1;
      end else if (w_return) begin
        r_status <= r_spsr;
        r_state  <= ST_USER;
        r_in_exc <= 1'b0;
      end else if (w_wr) begin
        r_status <= w_next;
      end
    end
  end

  assign bus.status      = r_status;
  assign bus.status_fwd  = (P_FWD & w_take) ? w_next
                                            : r_status;
  assign bus.cond_hazard = ~P_FWD & w_wr
                         & (bus.id_cond != COND_AL);
  assign o_in_exc        = r_in_exc;
  assign o_exc_err       = r_exc_err;

endmodule
